mc6502_rmw_sequencer: RTL and testbench
=======================================

Name: mc6502_rmw_sequencer

Overview:
- Executes the memory phase of 6502 read-modify-write instructions: ASL/LSR/ROL/ROR/INC/DEC on a memory operand.
- Fetches the operand over the CPU bus, feeds it to the existing MC6502Shifter (shift ops) or an internal ±1 adder (INC/DEC), and writes the result back with 6502 bus timing.
- Sits between the address-generation stage and the CPU bus; returns N/Z/C to the flag register.

Parameters:
- ADDR_WIDTH, 16, width of bus address and latched operand address.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  begin RMW sequence; sampled only in IDLE.
- i_op  in  3  operation code (package constants).
- i_addr  in  ADDR_WIDTH  effective address of operand.
- i_c  in  1  current carry flag; used as ROL/ROR carry-in.
- i_rdy  in  1  bus ready; low stalls the READ cycle only.
- i_rdata  in  8  bus read data.
- o_addr  out  ADDR_WIDTH  bus address.
- o_rd  out  1  bus read strobe.
- o_wr  out  1  bus write strobe.
- o_wdata  out  8  bus write data.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse; result flags valid.
- o_n, o_z, o_c  out  1 each  result flags.
- o_c_we  out  1  with o_done: 1 = load o_c into carry (shift ops), 0 = leave carry unchanged.

Behaviour:
- Reset: state=IDLE, o_addr=0, o_wdata=0, o_rd=0, o_wr=0, o_busy=0, o_done=0, o_n=o_z=o_c=0, o_c_we=0. Reset is asynchronous and active-high; asserting it mid-sequence drops o_rd/o_wr immediately and abandons the write-back.
- States: IDLE -> READ -> MODIFY -> WRITE -> IDLE.
- IDLE: on an edge with i_start=1, latch i_op, i_addr and i_c, then go to READ. i_start outside IDLE is ignored (no queueing).
- READ: o_rd=1, o_addr=latched addr. On an edge with i_rdy=1, capture i_rdata into operand reg and go to MODIFY. With i_rdy=0, hold READ indefinitely.
- MODIFY: NMOS dummy cycle. o_wr=1, o_wdata=original operand. Compute result combinationally from operand reg; latch result and flags at the edge; go to WRITE. i_rdy is ignored.
- WRITE: o_wr=1, o_wdata=result. At the edge go to IDLE and set o_done=1 for exactly one cycle.
- Latency: start edge to o_done high = 4 cycles with no stalls. Each READ stall cycle adds 1.
- A new i_start is accepted in the same cycle o_done is high.
- Shift ops (ASL=0, LSR=1, ROL=2, ROR=3): shifter rotate=op[1], right=op[0], c=latched i_c. Result, N, Z and C come from the shifter; o_c_we=1.
- INC=4 / DEC=5: result = operand ±1 mod 256 (0xFF+1=0x00, 0x00-1=0xFF). N=result[7], Z=(result==0). o_c unchanged; o_c_we=0.
- Reserved ops 6/7: full bus sequence runs; result=operand; N/Z from operand; o_c_we=0.
- o_n/o_z/o_c/o_c_we hold their last values until the next o_done.

Optional Feature:
- Macro MC6502_CMOS_RMW_EN.
- Defined: MODIFY issues a dummy read instead (o_rd=1, o_wr=0, same address, data discarded; i_rdy stalls MODIFY like READ). This gives 65C02 behaviour.
- Undefined: NMOS dummy write of the original value, as described in Behaviour.

Decomposition:
- Shared package mc6502_pkg holds:
  - op codes RMW_ASL..RMW_DEC;
  - state encoding (IDLE=0, READ=1, MODIFY=2, WRITE=3);
  - data width constant 8.
- Single sub-module: the existing MC6502Shifter, instantiated once. The ±1 adder and result mux stay inline.

Test Plan:
- ASL, addr 0x1234, rdata 0x80, c=0 -> READ@0x1234, wr 0x80 then 0x00; done with n=0 z=1 c=1 c_we=1.
- ROR, rdata 0x01, c=1 -> final write 0x80; n=1 z=0 c=1.
- DEC, rdata 0x00, c=1 -> final write 0xFF; n=1 z=0 c_we=0. INC on 0xFF -> 0x00, z=1.
- i_rdy low 3 cycles in READ -> o_rd held, o_done at cycle 7. i_start pulsed while busy -> ignored.
- rst asserted during MODIFY -> o_wr falls before the next edge; no WRITE cycle; back-to-back start on the done cycle is accepted.
- With MC6502_CMOS_RMW_EN: LSR 0x41 -> rd, rd, wr 0x20; c=1 n=0 z=0.

Source files
------------

// File: rtl/mc6502_pkg.sv
// Shared definitions for the 6502 read-modify-write sequencer: operation
// codes, sequencer state encoding and the data bus width.
package mc6502_pkg;

    localparam int DATA_W = 8;

    // RMW operation codes carried on i_op. Values 6 and 7 are reserved.
    localparam logic [2:0] RMW_ASL = 3'd0;
    localparam logic [2:0] RMW_LSR = 3'd1;
    localparam logic [2:0] RMW_ROL = 3'd2;
    localparam logic [2:0] RMW_ROR = 3'd3;
    localparam logic [2:0] RMW_INC = 3'd4;
    localparam logic [2:0] RMW_DEC = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        MODIFY = 2'd2,
        WRITE  = 2'd3
    } rmw_state_t;

endpackage

// File: rtl/mc6502_rmw_sequencer_shifter.sv
// MC6502Shifter: combinational one-bit shift/rotate unit with flag outputs.
// i_rotate feeds i_c into the vacated bit; otherwise a zero is shifted in.
module MC6502Shifter
    import mc6502_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_c,
    input  logic              i_rotate,
    input  logic              i_right,
    output logic [DATA_W-1:0] o_data,
    output logic              o_n,
    output logic              o_z,
    output logic              o_c
);

    logic w_fill;

    assign w_fill = i_rotate & i_c;

    // Shift/rotate result and the bit that falls out becomes the new carry.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        o_data = i_data;
        o_c    = 1'b0;
        if (i_right) begin
            o_data = {w_fill, i_data[DATA_W-1:1]};
            o_c    = i_data[0];
        end else begin
            o_data = {i_data[DATA_W-2:0], w_fill};
            o_c    = i_data[DATA_W-1];
        end
        o_n = o_data[DATA_W-1];
        o_z = (o_data == '0);
    end

endmodule

// File: rtl/mc6502_rmw_sequencer.sv
// mc6502_rmw_sequencer: bus sequencing for 6502 read-modify-write memory
// instructions (ASL/LSR/ROL/ROR/INC/DEC). Runs READ -> MODIFY -> WRITE and
// reports N/Z/C with a one-cycle o_done pulse.
// Build option MC6502_CMOS_RMW_EN: when defined, the MODIFY cycle is a dummy
// read (65C02 style, stallable by i_rdy); otherwise it is the NMOS dummy
// write of the unmodified operand.
module mc6502_rmw_sequencer
    import mc6502_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_c,
    input  logic                  i_rdy,
    input  logic [DATA_W-1:0]     i_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_rd,
    output logic                  o_wr,
    output logic [DATA_W-1:0]     o_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_n,
    output logic                  o_z,
    output logic                  o_c,
    output logic                  o_c_we
);

    rmw_state_t        r_state;
    logic [2:0]        r_op;
    logic              r_c_in;
    logic [DATA_W-1:0] r_operand;
    logic              r_res_n;
    logic              r_res_z;
    logic              r_res_c;
    logic              r_res_c_we;

    logic [DATA_W-1:0] w_sh_data;
    logic              w_sh_n;
    logic              w_sh_z;
    logic              w_sh_c;
    logic [DATA_W-1:0] w_result;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_c_we;
    logic              w_mod_go;
    logic              w_mod_rd;

`ifdef MC6502_CMOS_RMW_EN
    assign w_mod_go = i_rdy;
    assign w_mod_rd = 1'b1;
`else
    assign w_mod_go = 1'b1;
    assign w_mod_rd = 1'b0;
`endif

    MC6502Shifter u_shifter (
        .i_data   (r_operand),
        .i_c      (r_c_in),
        .i_rotate (r_op[1]),
        .i_right  (r_op[0]),
        .o_data   (w_sh_data),
        .o_n      (w_sh_n),
        .o_z      (w_sh_z),
        .o_c      (w_sh_c)
    );

    // Result mux: shifter for shift ops, inline +/-1 for INC/DEC, pass-through otherwise.
    always_comb begin
        w_result = r_operand;
        w_c      = r_c_in;
        w_c_we   = 1'b0;
        case (r_op)
            RMW_ASL, RMW_LSR, RMW_ROL, RMW_ROR: begin
                w_result = w_sh_data;
                w_c      = w_sh_c;
                w_c_we   = 1'b1;
            end
            RMW_INC: w_result = r_operand + 8'd1;
            RMW_DEC: w_result = r_operand - 8'd1;
            default: w_result = r_operand;
        endcase
        w_n = w_result[DATA_W-1];
        w_z = (w_result == '0);
        if (w_c_we) begin
            w_n = w_sh_n;
            w_z = w_sh_z;
        end
    end

    // Sequencer FSM with registered bus strobes, write data and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_c_in     <= 1'b0;
            r_operand  <= '0;
            r_res_n    <= 1'b0;
            r_res_z    <= 1'b0;
            r_res_c    <= 1'b0;
            r_res_c_we <= 1'b0;
            o_addr     <= '0;
            o_rd       <= 1'b0;
            o_wr       <= 1'b0;
            o_wdata    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_n        <= 1'b0;
            o_z        <= 1'b0;
            o_c        <= 1'b0;
            o_c_we     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_c_in  <= i_c;
                        o_addr  <= i_addr;
                        o_rd    <= 1'b1;
                        o_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (i_rdy) begin
                        r_operand <= i_rdata;
                        o_rd      <= w_mod_rd;
                        o_wr      <= ~w_mod_rd;
                        o_wdata   <= i_rdata;
                        r_state   <= MODIFY;
                    end
                end
                MODIFY: begin
                    if (w_mod_go) begin
                        r_res_n    <= w_n;
                        r_res_z    <= w_z;
                        r_res_c    <= w_c;
                        r_res_c_we <= w_c_we;
                        o_rd       <= 1'b0;
                        o_wr       <= 1'b1;
                        o_wdata    <= w_result;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    o_wr    <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    o_n     <= r_res_n;
                    o_z     <= r_res_z;
                    o_c_we  <= r_res_c_we;
                    if (r_res_c_we) begin
                        o_c <= r_res_c;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc6502_rmw_sequencer.sv
// Directed self-checking bench for mc6502_rmw_sequencer. Inputs are driven
// and outputs sampled 1 ns after the rising edge.
module tb_mc6502_rmw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [15:0] i_addr;
    logic        i_c;
    logic        i_rdy;
    logic [7:0]  i_rdata;
    logic [15:0] o_addr;
    logic        o_rd;
    logic        o_wr;
    logic [7:0]  o_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_n;
    logic        o_z;
    logic        o_c;
    logic        o_c_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc6502_rmw_sequencer #(.ADDR_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_addr  (i_addr),
        .i_c     (i_c),
        .i_rdy   (i_rdy),
        .i_rdata (i_rdata),
        .o_addr  (o_addr),
        .o_rd    (o_rd),
        .o_wr    (o_wr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_n     (o_n),
        .o_z     (o_z),
        .o_c     (o_c),
        .o_c_we  (o_c_we)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic n, input logic z,
                               input logic c, input logic c_we);
        check({tag, ".n"},    o_n,    n);
        check({tag, ".z"},    o_z,    z);
        check({tag, ".c"},    o_c,    c);
        check({tag, ".c_we"}, o_c_we, c_we);
    endtask

    // One unstalled RMW transaction; returns in the o_done cycle.
    task automatic run_rmw(input string tag, input logic [2:0] op, input logic [15:0] addr,
                           input logic c, input logic [7:0] rdata, input logic [7:0] exp_res);
        i_start = 1'b1; i_op = op; i_addr = addr; i_c = c; i_rdata = rdata; i_rdy = 1'b1;
        tick();
        // Scramble inputs that must have been latched at start.
        i_start = 1'b0; i_op = 3'd7; i_c = ~c; i_addr = 16'hFFFF;
        check({tag, ".read.rd"},   o_rd,   1'b1);
        check({tag, ".read.wr"},   o_wr,   1'b0);
        check({tag, ".read.addr"}, o_addr, addr);
        check({tag, ".read.busy"}, o_busy, 1'b1);
        check({tag, ".read.done"}, o_done, 1'b0);
        tick();
        i_rdata = 8'hEE;
`ifdef MC6502_CMOS_RMW_EN
        check({tag, ".mod.rd"}, o_rd, 1'b1);
        check({tag, ".mod.wr"}, o_wr, 1'b0);
`else
        check({tag, ".mod.rd"},    o_rd,    1'b0);
        check({tag, ".mod.wr"},    o_wr,    1'b1);
        check({tag, ".mod.wdata"}, o_wdata, rdata);
`endif
        check({tag, ".mod.addr"}, o_addr, addr);
        tick();
        check({tag, ".wr.rd"},    o_rd,    1'b0);
        check({tag, ".wr.wr"},    o_wr,    1'b1);
        check({tag, ".wr.wdata"}, o_wdata, exp_res);
        check({tag, ".wr.addr"},  o_addr,  addr);
        tick();
        check({tag, ".done"},      o_done, 1'b1);
        check({tag, ".done.wr"},   o_wr,   1'b0);
        check({tag, ".done.busy"}, o_busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        rst = 1'b1; i_start = 1'b0; i_op = 3'd0; i_addr = 16'h0000;
        i_c = 1'b0; i_rdy = 1'b1; i_rdata = 8'h00;
        tick();
        tick();
        check("rst.addr",  o_addr,  16'h0000);
        check("rst.rd",    o_rd,    1'b0);
        check("rst.wr",    o_wr,    1'b0);
        check("rst.wdata", o_wdata, 8'h00);
        check("rst.busy",  o_busy,  1'b0);
        check("rst.done",  o_done,  1'b0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // ASL 0x80, c=0 -> 0x00, carry out 1.
        run_rmw("asl", 3'd0, 16'h1234, 1'b0, 8'h80, 8'h00);
        check_flags("asl", 1'b0, 1'b1, 1'b1, 1'b1);
        // ROR started in the done cycle of ASL: 0x01, c=1 -> 0x80, carry out 1.
        run_rmw("ror", 3'd3, 16'h00F0, 1'b1, 8'h01, 8'h80);
        check_flags("ror", 1'b1, 1'b0, 1'b1, 1'b1);
        // ROL 0x40, c=1 -> 0x81, carry out 0.
        run_rmw("rol", 3'd2, 16'h4000, 1'b1, 8'h40, 8'h81);
        check_flags("rol", 1'b1, 1'b0, 1'b0, 1'b1);
        // LSR 0x41 -> 0x20, carry out 1.
        run_rmw("lsr", 3'd1, 16'h0010, 1'b0, 8'h41, 8'h20);
        check_flags("lsr", 1'b0, 1'b0, 1'b1, 1'b1);
        // DEC 0x00 -> 0xFF; carry left at its previous value 1.
        run_rmw("dec", 3'd5, 16'h0020, 1'b0, 8'h00, 8'hFF);
        check_flags("dec", 1'b1, 1'b0, 1'b1, 1'b0);
        // INC 0xFF -> 0x00.
        run_rmw("inc", 3'd4, 16'h0021, 1'b0, 8'hFF, 8'h00);
        check_flags("inc", 1'b0, 1'b1, 1'b1, 1'b0);
        // Reserved op 6 passes 0x80 through; N from operand.
        run_rmw("rsv", 3'd6, 16'h0022, 1'b0, 8'h80, 8'h80);
        check_flags("rsv", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("idle.done", o_done, 1'b0);

        // Three READ stall cycles, stray start pulse while busy.
        i_start = 1'b1; i_op = 3'd4; i_addr = 16'h0200; i_c = 1'b0;
        i_rdata = 8'h7F; i_rdy = 1'b0;
        tick();
        cycles = 1;
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                i_start = 1'b1; i_op = 3'd0; i_addr = 16'hBEEF;
            end
            tick();
            cycles++;
            i_start = 1'b0;
            check("stall.rd", o_rd, 1'b1);
            check("stall.wr", o_wr, 1'b0);
        end
        i_rdy = 1'b1;
        while (!o_done && cycles < 20) begin
            tick();
            cycles++;
        end
        check("stall.latency", cycles, 7);
        check("stall.wdata",   o_wdata, 8'h80);
        check_flags("stall", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("stall.no_queue", o_busy, 1'b0);

        // Reset asserted during MODIFY abandons the write-back immediately.
        i_start = 1'b1; i_op = 3'd1; i_addr = 16'h0300; i_rdata = 8'h02;
        tick();
        i_start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("rstmod.wr",   o_wr,   1'b0);
        check("rstmod.rd",   o_rd,   1'b0);
        check("rstmod.busy", o_busy, 1'b0);
        check_flags("rstmod", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        check("rstmod.no_write", o_wr,   1'b0);
        check("rstmod.no_done",  o_done, 1'b0);
        tick();
        check("rstmod.no_done2", o_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
